// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_pkg
// Description : Shared defaults, the buffered-row entry layout and a
//               counter-width helper for the sensor frame reader.
//               Entry layout (MSB first): first, last, row data. Column c
//               occupies data[c*PIXEL_BITS +: PIXEL_BITS].
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    localparam int DEFAULT_PIXEL_BITS = 8;
    localparam int DEFAULT_N_COLS     = 2;
    localparam int DEFAULT_N_ROWS     = 2;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic                                          first;
        logic                                          last;
        logic [DEFAULT_N_COLS*DEFAULT_PIXEL_BITS-1:0]  data;
    } row_entry_t;

    // Counter/pointer width for a range of 'value' states; never below 1 bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : row_fifo
// Description : Single-clock synchronous FIFO holding whole sensor rows.
//               A push while full is accepted only if a pop happens in the
//               same cycle; a pop while empty is ignored.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_push/i_data - write request and entry
//               i_pop        - remove head entry
//               o_head       - current head entry (valid when !o_empty)
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module row_fifo
    import sensor_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = clog2_min1(DEPTH);
    localparam logic [c_AW:0] c_FULL_COUNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == c_FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the slot the simultaneous push needs.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sensor_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_reader
// Description : Captures parallel sensor rows, buffers them in a row FIFO and
//               serialises them as a valid/ready pixel stream tagged with
//               start-of-frame, end-of-line and end-of-frame.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               frame_start, row_valid, row_data - row readout input
//               pix_valid/pix_ready/pix_data/pix_sof/pix_eol/pix_eof
//                                     - pixel stream output
//               frame_done            - pulse, cycle after the eof transfer
//               overflow, protocol_err - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_frame_reader
    import sensor_pkg::*;
#(
    parameter int PIXEL_BITS = DEFAULT_PIXEL_BITS,
    parameter int N_COLS     = DEFAULT_N_COLS,
    parameter int N_ROWS     = DEFAULT_N_ROWS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic                         row_valid,
    input  logic [N_COLS*PIXEL_BITS-1:0] row_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [PIXEL_BITS-1:0]        pix_data,
    output logic                         pix_sof,
    output logic                         pix_eol,
    output logic                         pix_eof,
    output logic                         frame_done,
    output logic                         overflow,
    output logic                         protocol_err
);

    localparam int c_ROW_W   = N_COLS * PIXEL_BITS;
    localparam int c_ENTRY_W = c_ROW_W + 2;
    localparam int c_RW      = clog2_min1(N_ROWS);
    localparam int c_CW      = clog2_min1(N_COLS);

    localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(N_ROWS - 1);
    localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(N_COLS - 1);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_CAPTURE = 1'b1;

    logic [0:0]      r_state;
    logic [c_RW-1:0] r_row_cnt;
    logic [c_CW-1:0] r_col_cnt;
    logic            r_frame_done;
    logic            r_overflow;
    logic            r_protocol_err;

    logic                  w_in_frame;
    logic [c_RW-1:0]       w_row_idx;
    logic                  w_row_take;
    logic [c_ENTRY_W-1:0]  w_entry;
    logic [c_ENTRY_W-1:0]  w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_transfer;
    logic                  w_last_col;
    logic                  w_pop;
    logic [PIXEL_BITS-1:0] w_cols [N_COLS];

    // A frame_start in the same cycle as row_valid opens (or restarts) the
    // frame first, so that row becomes row 0.
    assign w_in_frame = frame_start | (r_state == c_ST_CAPTURE);
    assign w_row_idx  = frame_start ? '0 : r_row_cnt;
    assign w_row_take = row_valid & w_in_frame;
    assign w_entry    = {(w_row_idx == '0), (w_row_idx == c_LAST_ROW), row_data};

    row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_row_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_row_take),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    for (genvar c = 0; c < N_COLS; c++) begin : g_cols
        assign w_cols[c] = w_head[c*PIXEL_BITS +: PIXEL_BITS];
    end

    assign w_transfer = pix_valid & pix_ready;
    assign w_last_col = (r_col_cnt == c_LAST_COL);
    assign w_pop      = w_transfer & w_last_col;

    // Tags and data are forced to zero while nothing is queued so the idle
    // stream never exposes stale FIFO contents.
    assign pix_valid    = ~w_empty;
    assign pix_data     = pix_valid ? w_cols[r_col_cnt] : '0;
    assign pix_sof      = pix_valid & w_head[c_ENTRY_W-1] & (r_col_cnt == '0);
    assign pix_eol      = pix_valid & w_last_col;
    assign pix_eof      = pix_eol & w_head[c_ENTRY_W-2];
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;
    assign protocol_err = r_protocol_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_row_cnt      <= '0;
            r_col_cnt      <= '0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_frame_done <= w_transfer & pix_eof;

            // Dropped rows still advance row_cnt so later tags stay aligned.
            if (w_row_take & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
            if (row_valid & ~w_in_frame) begin
                r_protocol_err <= 1'b1;
            end

            if (w_transfer) begin
                r_col_cnt <= w_last_col ? '0 : r_col_cnt + c_CW'(1);
            end

            if (w_row_take) begin
                if (w_row_idx == c_LAST_ROW) begin
                    r_state   <= c_ST_IDLE;
                    r_row_cnt <= '0;
                end else begin
                    r_state   <= c_ST_CAPTURE;
                    r_row_cnt <= w_row_idx + c_RW'(1);
                end
            end else if (frame_start) begin
                r_state   <= c_ST_CAPTURE;
                r_row_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sensor_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sensor_frame_reader
// Description : Directed self-checking bench for sensor_frame_reader at the
//               default sizes (8-bit pixels, 2 columns, 2 rows, 4-row FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_frame_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        row_valid = 1'b0;
    logic [15:0] row_data = 16'h0;
    logic        pix_ready = 1'b0;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic        frame_done;
    logic        overflow;
    logic        protocol_err;

    always #5 clk = ~clk;

    sensor_frame_reader #(
        .PIXEL_BITS (8),
        .N_COLS     (2),
        .N_ROWS     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .row_valid    (row_valid),
        .row_data     (row_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_sof      (pix_sof),
        .pix_eol      (pix_eol),
        .pix_eof      (pix_eof),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .protocol_err (protocol_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int stalls = 0;
    int fd_cnt = 0;
    logic rdy = 1'b1;
    logic toggle = 1'b0;

    // Pixel words are {sof, eol, eof, data}.
    logic [10:0] got_q [$];
    logic [10:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] px(input logic s, input logic l, input logic f, input logic [7:0] d);
        return {s, l, f, d};
    endfunction

    // Stream monitor on the falling edge: records transfers, checks that a
    // stalled pixel is held and that frame_done follows exactly one eof.
    logic        prev_stall = 1'b0;
    logic        prev_eof_xfer = 1'b0;
    logic        prev_reset = 1'b1;
    logic [10:0] prev_word = 11'h0;
    logic [10:0] cur_word;
    always @(negedge clk) begin
        cur_word = {pix_sof, pix_eol, pix_eof, pix_data};
        if (prev_stall && !prev_reset && pix_valid)
            check_eq("stall_hold", 32'(cur_word), 32'(prev_word));
        if (prev_eof_xfer || frame_done)
            check_eq("frame_done_timing", 32'(frame_done), 32'(prev_eof_xfer));
        if (frame_done) fd_cnt++;
        if (pix_valid && pix_ready && !reset) got_q.push_back(cur_word);
        if (pix_valid && !pix_ready) stalls++;
        prev_stall    = pix_valid && !pix_ready;
        prev_eof_xfer = pix_valid && pix_ready && pix_eof && !reset;
        prev_reset    = reset;
        prev_word     = cur_word;
    end

    task automatic cyc(input logic fs, input logic rv, input logic [15:0] d);
        @(posedge clk);
        #1;
        frame_start = fs;
        row_valid   = rv;
        row_data    = d;
        pix_ready   = toggle ? ~pix_ready : rdy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        frame_start = 1'b0;
        row_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, 32'({pix_valid, pix_sof, pix_eol, pix_eof, frame_done,
                           overflow, protocol_err, pix_data}), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        fd_cnt = 0;
        stalls = 0;
    endtask

    task automatic compare_stream(input string tag, input int frames);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_pix%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_frames"}, 32'(fd_cnt), 32'(frames));
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    task automatic expect_basic;
        exp_q.push_back(px(1, 0, 0, 8'h11));
        exp_q.push_back(px(0, 1, 0, 8'h22));
        exp_q.push_back(px(0, 0, 0, 8'h33));
        exp_q.push_back(px(0, 1, 1, 8'h44));
    endtask

    initial begin
        do_reset("reset_state");

        // 1: basic frame with ready held high, plus first-pixel latency.
        rdy = 1'b1;
        cyc(1, 0, 16'h0);
        cyc(0, 1, 16'h2211);
        cyc(0, 1, 16'h4433);
        @(negedge clk);
        check_eq("t1_latency", 32'({pix_valid, pix_sof, pix_data}), 32'({1'b1, 1'b1, 8'h11}));
        idle(8);
        expect_basic();
        compare_stream("t1", 1);
        check_eq("t1_flags", 32'({overflow, protocol_err}), 32'h0);

        // 2: same frame with ready toggling every cycle.
        do_reset("t2_reset");
        toggle = 1'b1;
        cyc(1, 0, 16'h0);
        cyc(0, 1, 16'h2211);
        cyc(0, 1, 16'h4433);
        idle(14);
        toggle = 1'b0;
        expect_basic();
        compare_stream("t2", 1);
        check_eq("t2_stalled", 32'(stalls > 0), 32'h1);

        // 3: three frames into a stalled sink; the last two rows overflow.
        do_reset("t3_reset");
        rdy = 1'b0;
        cyc(1, 0, 16'h0);
        cyc(0, 1, 16'h0201);
        cyc(0, 1, 16'h0403);
        cyc(1, 0, 16'h0);
        cyc(0, 1, 16'h0605);
        cyc(0, 1, 16'h0807);
        cyc(1, 0, 16'h0);
        @(negedge clk);
        check_eq("t3_full_no_ovf", 32'({pix_valid, overflow}), 32'({1'b1, 1'b0}));
        cyc(0, 1, 16'h0A09);
        cyc(0, 1, 16'h0C0B);
        cyc(0, 0, 16'h0);
        @(negedge clk);
        check_eq("t3_overflow", 32'(overflow), 32'h1);
        check_eq("t3_held_back", 32'(got_q.size()), 32'h0);
        rdy = 1'b1;
        idle(14);
        exp_q.push_back(px(1, 0, 0, 8'h01));
        exp_q.push_back(px(0, 1, 0, 8'h02));
        exp_q.push_back(px(0, 0, 0, 8'h03));
        exp_q.push_back(px(0, 1, 1, 8'h04));
        exp_q.push_back(px(1, 0, 0, 8'h05));
        exp_q.push_back(px(0, 1, 0, 8'h06));
        exp_q.push_back(px(0, 0, 0, 8'h07));
        exp_q.push_back(px(0, 1, 1, 8'h08));
        compare_stream("t3", 2);
        check_eq("t3_ovf_sticky", 32'(overflow), 32'h1);

        // 4a: row outside any frame.
        do_reset("t4_reset");
        cyc(0, 1, 16'h5555);
        cyc(0, 0, 16'h0);
        @(negedge clk);
        check_eq("t4_perr_idle", 32'({protocol_err, pix_valid}), 32'({1'b1, 1'b0}));
        idle(3);
        check_eq("t4_no_pixels", 32'(got_q.size()), 32'h0);
        // 4b: a third row inside one frame.
        do_reset("t4b_reset");
        cyc(1, 0, 16'h0);
        cyc(0, 1, 16'h2211);
        cyc(0, 1, 16'h4433);
        cyc(0, 0, 16'h0);
        @(negedge clk);
        check_eq("t4_perr_clear", 32'(protocol_err), 32'h0);
        cyc(0, 1, 16'h6655);
        cyc(0, 0, 16'h0);
        @(negedge clk);
        check_eq("t4_perr_extra", 32'(protocol_err), 32'h1);
        idle(8);
        expect_basic();
        compare_stream("t4", 1);

        // 5: frame_start and row_valid together.
        do_reset("t5_reset");
        rdy = 1'b0;
        cyc(1, 1, 16'hBBAA);
        cyc(0, 0, 16'h0);
        @(negedge clk);
        check_eq("t5_head", 32'({pix_valid, pix_sof, pix_eol, pix_eof, pix_data}),
                 32'({1'b1, 1'b1, 1'b0, 1'b0, 8'hAA}));
        rdy = 1'b1;
        idle(6);
        exp_q.push_back(px(1, 0, 0, 8'hAA));
        exp_q.push_back(px(0, 1, 0, 8'hBB));
        compare_stream("t5", 0);

        // 6: reset in the middle of a frame.
        do_reset("t6_reset0");
        rdy = 1'b0;
        cyc(1, 0, 16'h0);
        cyc(0, 1, 16'h2211);
        cyc(0, 0, 16'h0);
        @(negedge clk);
        check_eq("t6_queued", 32'(pix_valid), 32'h1);
        do_reset("t6_midframe_reset");
        rdy = 1'b1;
        idle(4);
        check_eq("t6_flushed", 32'(got_q.size()), 32'h0);
        cyc(1, 0, 16'h0);
        cyc(0, 1, 16'h2211);
        cyc(0, 1, 16'h4433);
        idle(8);
        expect_basic();
        compare_stream("t6", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
